// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared floating-point types, constants and operand classification
//
// Purpose : common definitions for the FP datapath blocks (divide_top, multiply_top).
// Contents: default field widths, quiet-NaN constant, FSM state enum,
//           operand-class enum and classify() helper.

package float_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;

    // Canonical quiet NaN for the default format: {0, all-ones, 1, 0..0}
    localparam logic [DEF_EXP_W+DEF_MAN_W:0] QNAN =
        {1'b0, {DEF_EXP_W{1'b1}}, 1'b1, {(DEF_MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORMALIZE,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } op_class_t;

    // Denormals (exp==0) are deliberately reported as ZERO: they are flushed.
    function automatic op_class_t classify(
        input logic exp_zero,
        input logic exp_ones,
        input logic man_nz
    );
        if (exp_zero) begin
            return ZERO;
        end
        if (exp_ones) begin
            return man_nz ? NAN : INF;
        end
        return NORM;
    endfunction

endpackage

// File: rtl/mantissa_divider.sv
// rtl/mantissa_divider.sv - restoring iterative mantissa divider, one quotient bit per cycle
//
// Purpose : divides {1,ma} by {1,mb}, producing MAN_W+2 quotient bits, MSB weight 2^0.
// Ports   : clk_i       clock
//           reset_i     asynchronous active-low reset
//           start_i     load operands and begin iterating
//           dividend_i  {1, ma}
//           divisor_i   {1, mb}
//           quotient_o  quotient, final one cycle after done_o
//           done_o      high during the final iteration cycle

module mantissa_divider #(
    parameter int MAN_W = 23
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [MAN_W:0]   dividend_i,
    input  logic [MAN_W:0]   divisor_i,
    output logic [MAN_W+1:0] quotient_o,
    output logic             done_o
);

    localparam int QW = MAN_W + 2;
    localparam int CW = $clog2(QW + 1);

    logic [QW-1:0] rem_q;
    logic [QW-1:0] div_q;
    logic [QW-1:0] q_q;
    logic [CW-1:0] cnt_q;

    logic          ge;
    logic [QW-1:0] rem_sel;

    // rem < 2*div always holds, so QW bits suffice for the shifted remainder.
    always_comb begin
        ge      = (rem_q >= div_q);
        rem_sel = ge ? (rem_q - div_q) : rem_q;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rem_q <= '0;
            div_q <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            rem_q <= {1'b0, dividend_i};
            div_q <= {1'b0, divisor_i};
            q_q   <= '0;
            cnt_q <= CW'(QW);
        end else if (cnt_q != '0) begin
            rem_q <= rem_sel << 1;
            q_q   <= {q_q[QW-2:0], ge};
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign quotient_o = q_q;
    assign done_o     = (cnt_q == CW'(1));

endmodule

// File: rtl/divide_top.sv
// rtl/divide_top.sv - iterative floating-point divider, result_o = a_i / b_i
//
// Purpose : restoring division, truncation rounding, denormals flushed to zero.
// Ports   : clk_i        clock
//           reset_i      asynchronous active-low reset
//           in_valid_i   operands valid
//           in_ready_o   operands accepted (IDLE only)
//           a_i, b_i     dividend / divisor {sign, exponent, mantissa}
//           out_valid_o  result valid, held until out_ready_i
//           out_ready_i  consumer accepts result
//           result_o     registered quotient

module divide_top
    import float_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] result_o
);

    localparam int QW = MAN_W + 2;

    typedef logic signed [EXP_W+1:0] sexp_t;

    localparam sexp_t BIAS    = sexp_t'(2**(EXP_W-1) - 1);
    localparam sexp_t EXP_ALL = sexp_t'(2**EXP_W - 1);

    localparam logic [W-1:0] QNAN_W =
        (EXP_W == DEF_EXP_W && MAN_W == DEF_MAN_W) ? W'(QNAN)
        : {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    state_t state_q, state_d;

    logic         sign_q;
    sexp_t        exp_diff_q;
    logic [W-1:0] result_q;

    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   ma, mb;
    op_class_t          ca, cb;

    logic               accept;
    logic               start;
    logic               is_special;
    logic [W-1:0]       special_res;
    sexp_t              exp_diff_in;

    logic [QW-1:0]      quot;
    logic               core_done;

    sexp_t              e_norm;
    logic [MAN_W-1:0]   man_norm;
    logic [W-1:0]       norm_res;

    assign {sa, ea, ma} = a_i;
    assign {sb, eb, mb} = b_i;

    mantissa_divider #(
        .MAN_W (MAN_W)
    ) u_core (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (start),
        .dividend_i ({1'b1, ma}),
        .divisor_i  ({1'b1, mb}),
        .quotient_o (quot),
        .done_o     (core_done)
    );

    // Operand classification and special-case result selection.
    always_comb begin
        ca          = classify(ea == '0, &ea, |ma);
        cb          = classify(eb == '0, &eb, |mb);
        is_special  = 1'b1;
        special_res = '0;
        if (ca == NAN || cb == NAN || (ca == ZERO && cb == ZERO) || (ca == INF && cb == INF)) begin
            special_res = QNAN_W;
        end else if (ca == INF || cb == ZERO) begin
            special_res = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (ca == ZERO || cb == INF) begin
            special_res = {sa ^ sb, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            is_special  = 1'b0;
        end
        exp_diff_in = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
    end

    // Quotient lies in (0.5, 2): either the MSB is set, or the next bit is
    // and the result needs one left shift with the exponent decremented.
    always_comb begin
        if (quot[QW-1]) begin
            man_norm = quot[MAN_W:1];
            e_norm   = exp_diff_q;
        end else begin
            man_norm = quot[MAN_W-1:0];
            e_norm   = exp_diff_q - sexp_t'(1);
        end
        if (e_norm >= EXP_ALL) begin
            norm_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (e_norm <= sexp_t'(0)) begin
            norm_res = {sign_q, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            norm_res = {sign_q, e_norm[EXP_W-1:0], man_norm};
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (in_valid_i) state_d = is_special ? DONE : DIVIDE;
            DIVIDE:    if (core_done)  state_d = NORMALIZE;
            NORMALIZE: state_d = DONE;
            DONE:      if (out_ready_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        accept      = (state_q == IDLE) && in_valid_i;
        start       = accept && !is_special;
        in_ready_o  = (state_q == IDLE) && reset_i;
        out_valid_o = (state_q == DONE);
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sign_q     <= 1'b0;
            exp_diff_q <= '0;
            result_q   <= '0;
        end else begin
            if (accept) begin
                sign_q     <= sa ^ sb;
                exp_diff_q <= exp_diff_in;
                if (is_special) begin
                    result_q <= special_res;
                end
            end
            if (state_q == NORMALIZE) begin
                result_q <= norm_res;
            end
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_divide_top.sv
// tb/tb_divide_top.sv - self-checking directed bench for divide_top

module tb_divide_top;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        string       name;
    } vec_t;

    always #5 clk_i = ~clk_i;

    divide_top dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present one operand pair for a single cycle, scramble the operand bus
    // afterwards, then count cycles (accept edge = 1) until out_valid_o.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, output int lat);
        a_i        = a;
        b_i        = b;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        a_i        = $urandom;
        b_i        = $urandom;
        lat        = 1;
        while (!out_valid_o && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
    endtask

    task automatic run_vectors(input vec_t v[$]);
        int lat;
        foreach (v[i]) begin
            tests_run++;
            if (in_ready_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s ready_before: got %b want 1", v[i].name, in_ready_o);
            end
            issue(v[i].a, v[i].b, lat);
            tests_run++;
            if (lat !== v[i].lat) begin
                tests_failed++;
                $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat);
            end
            tests_run++;
            if (result_o !== v[i].res) begin
                tests_failed++;
                $display("FAIL %s result: got %h want %h", v[i].name, result_o, v[i].res);
            end
            release_result();
        end
    endtask

    task automatic test_reset();
        reset_i     = 1'b0;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b0;
        a_i         = 32'h40C00000;
        b_i         = 32'h40000000;
        step();
        step();
        tests_run++;
        if (in_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready_o);
        end
        tests_run++;
        if (out_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid_o);
        end
        tests_run++;
        if (result_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_result: got %h want 00000000", result_o);
        end
        in_valid_i = 1'b0;
        reset_i    = 1'b1;
        #1;
        tests_run++;
        if (in_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready_o);
        end
        step();
    endtask

    task automatic test_normal();
        vec_t v[$];
        v.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 27, "6/2"});
        v.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27, "1/3"});
        v.push_back('{32'hC0F00000, 32'h40200000, 32'hC0400000, 27, "-7.5/2.5"});
        run_vectors(v);
    endtask

    task automatic test_specials();
        vec_t v[$];
        v.push_back('{32'h3F800000, 32'h80000000, 32'hFF800000, 1, "1/-0"});
        v.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 1, "0/0"});
        v.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1, "inf/inf"});
        v.push_back('{32'h7F800001, 32'h00000000, 32'h7FC00000, 1, "nan/0"});
        v.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 1, "-inf/2"});
        v.push_back('{32'h40000000, 32'hFF800000, 32'h80000000, 1, "2/-inf"});
        v.push_back('{32'h00400000, 32'h3F800000, 32'h00000000, 1, "denorm/1"});
        v.push_back('{32'hBF800000, 32'h00000001, 32'hFF800000, 1, "-1/denorm"});
        run_vectors(v);
    endtask

    task automatic test_range();
        vec_t v[$];
        v.push_back('{32'h7F000000, 32'h00800000, 32'h7F800000, 27, "overflow"});
        v.push_back('{32'h00800000, 32'h7F000000, 32'h00000000, 27, "underflow"});
        run_vectors(v);
    endtask

    task automatic test_backpressure();
        int lat;
        issue(32'h40C00000, 32'h40000000, lat);
        tests_run++;
        if (result_o !== 32'h40400000) begin
            tests_failed++;
            $display("FAIL bp_result: got %h want 40400000", result_o);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid_i = 1'b1;
            a_i        = 32'h3F800000;
            b_i        = 32'h40400000;
            step();
            tests_run++;
            if (out_valid_o !== 1'b1 || result_o !== 32'h40400000 || in_ready_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold cycle %0d: got v=%b r=%h rdy=%b want v=1 r=40400000 rdy=0",
                         i, out_valid_o, result_o, in_ready_o);
            end
        end
        in_valid_i = 1'b0;
        release_result();
        tests_run++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_reset_mid_divide();
        int lat;
        a_i        = 32'h3F800000;
        b_i        = 32'h40400000;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        repeat (10) step();
        tests_run++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_busy: got v=%b rdy=%b want v=0 rdy=0", out_valid_o, in_ready_o);
        end
        reset_i = 1'b0;
        #1;
        tests_run++;
        if (out_valid_o !== 1'b0 || result_o !== 32'h0 || in_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: got v=%b r=%h rdy=%b want v=0 r=00000000 rdy=0",
                     out_valid_o, result_o, in_ready_o);
        end
        step();
        reset_i = 1'b1;
        #1;
        tests_run++;
        if (in_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_release_ready: got %b want 1", in_ready_o);
        end
        step();
        issue(32'h40C00000, 32'h40000000, lat);
        tests_run++;
        if (lat !== 27 || result_o !== 32'h40400000) begin
            tests_failed++;
            $display("FAIL mid_next_op: got lat=%0d r=%h want lat=27 r=40400000", lat, result_o);
        end
        release_result();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal();
        test_specials();
        test_range();
        test_backpressure();
        test_reset_mid_divide();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
